regfile_sb: RTL

Parametrised register file with a write-back scoreboard. It is the successor to the 16×16 register file in the single-cycle/pipelined datapath. It keeps the existing semantics: two combinational read ports, a hard-wired zero register at address 0, and a special condition register T. It adds configurable width and depth, selectable T-write semantics, same-cycle write bypass, and a pending-write scoreboard. The pipeline control uses the scoreboard to detect RAW hazards on in-flight destination registers.

---
 rtl/regfile_sb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Parametrised register file: two combinational read ports, zero register at
// address 0, transformed condition register T, write bypass and a pending-write scoreboard.
module regfile_sb #(
  parameter int DW     = 16,
  parameter int AW     = 4,
  parameter int T_ADDR = 8,
  parameter int T_MODE = 0,
  parameter int BYPASS = 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          RegWre,
  input  logic [AW-1:0] WriteReg,
  input  logic [DW-1:0] WriteData,
  input  logic [AW-1:0] Rs,
  input  logic [AW-1:0] Rt,
  output logic [DW-1:0] ReadData1,
  output logic [DW-1:0] ReadData2,
  input  logic          IssueValid,
  input  logic [AW-1:0] IssueReg,
  input  logic          Flush,
  output logic          Busy1,
  output logic          Busy2,
  output logic [AW:0]   PendCnt,
  output logic          TFlag
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW-1:0] T_IDX = AW'(T_ADDR);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [DW-1:0] r_q [DEPTH];
  logic [DW-1:0] r_d [DEPTH];
  logic [DEPTH-1:0] p_q, p_d;
  logic [AW:0]   pend_cnt_q, pend_cnt_d;

  logic          wr_en;
  logic          iss_en;
  logic [DW-1:0] t_val;
  logic [DW-1:0] wr_val;
  logic          cnt_inc;
  logic          cnt_dec;

  // Effective write value: only the T register sees the transform.
  always_comb begin
    wr_en  = RegWre && (WriteReg != '0);
    iss_en = IssueValid && (IssueReg != '0);
    if (T_MODE == 0) begin
      t_val = DW'(WriteData == '0);
    end else if (T_MODE == 1) begin
      t_val = DW'(WriteData[DW-1]);
    end else begin
      t_val = WriteData;
    end
    wr_val = (WriteReg == T_IDX) ? t_val : WriteData;
  end

  always_comb begin
    ReadData1 = r_q[Rs];
    Busy1     = p_q[Rs];
    if ((BYPASS != 0) && wr_en && (WriteReg == Rs)) begin
      ReadData1 = wr_val;
      Busy1     = 1'b0;
    end
    if (Rs == '0) begin
      ReadData1 = '0;
      Busy1     = 1'b0;
    end
  end

  always_comb begin
    ReadData2 = r_q[Rt];
    Busy2     = p_q[Rt];
    if ((BYPASS != 0) && wr_en && (WriteReg == Rt)) begin
      ReadData2 = wr_val;
      Busy2     = 1'b0;
    end
    if (Rt == '0) begin
      ReadData2 = '0;
      Busy2     = 1'b0;
    end
  end

  // Issue is applied after the write-clear so a new producer wins on the same register.
  always_comb begin
    r_d = r_q;
    if (wr_en) begin
      r_d[WriteReg] = wr_val;
    end
    p_d = p_q;
    if (Flush) begin
      p_d = '0;
    end else begin
      if (wr_en) begin
        p_d[WriteReg] = 1'b0;
      end
      if (iss_en) begin
        p_d[IssueReg] = 1'b1;
      end
    end
    p_d[0] = 1'b0;
  end

  // Counter tracks popcount(p) incrementally from the same set/clear events.
  always_comb begin
    cnt_inc    = iss_en && !p_q[IssueReg];
    cnt_dec    = wr_en && p_q[WriteReg] && !(iss_en && (IssueReg == WriteReg));
    pend_cnt_d = pend_cnt_q;
    if (Flush) begin
      pend_cnt_d = '0;
    end else if (cnt_inc && !cnt_dec) begin
      pend_cnt_d = pend_cnt_q + CNT_ONE;
    end else if (cnt_dec && !cnt_inc) begin
      pend_cnt_d = pend_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_q[k] <= '0;
      end
      p_q        <= '0;
      pend_cnt_q <= '0;
    end else begin
      r_q        <= r_d;
      p_q        <= p_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign PendCnt = pend_cnt_q;
  assign TFlag   = r_q[T_IDX][0];

endmodule
